counter_serial_rx: RTL and testbench
====================================

// Module: counter_serial_rx
// PURPOSE
// - Receive end of the multichannel counter serial link: deserialises serial_in framed by sl_in and addr_in[2:0].
// - Rebuilds per-channel count words into an 8-entry register file, with per-word channel-overflow flags.
// - Keeps sticky global and RTC overflow status.
// - Sits on the capture/readout board side, downstream of the counter top's serial_out/SL_out/a0..a2/ovf_* pins.
// PARAMETERS
// - WIDTH        16  bits per count word; also the shift length per frame
// - NCH           8  channels; fixed by the 3-bit address
// - SYNC_STAGES   2  input synchroniser depth (0 = inputs already on clk)
// PORTS
// - clk          in   1      clock
// - reset        in   1      synchronous, active-high reset
// - serial_in    in   1      serial data, MSB first
// - sl_in        in   1      1 = load phase (addr valid), 0 = shift phase
// - addr_in      in   3      channel address (a2..a0), valid while sl_in=1
// - ovf_ch_in    in   1      channel-overflow flag of the current word
// - ovf_glb_in   in   1      global overflow
// - ovf_rtc_in   in   1      RTC overflow
// - clr_status   in   1      pulse: clear sticky status
// - rd_addr      in   3      register-file read address
// - rd_data      out  WIDTH  stored word at rd_addr (combinational read)
// - rd_ovf       out  1      stored channel-overflow flag at rd_addr
// - rd_valid     out  1      entry at rd_addr written since reset
// - word_valid   out  1      1-cycle pulse: a word completed
// - word_addr    out  3      channel of the completed word
// - word_data    out  WIDTH  completed word
// - frame_err    out  1      1-cycle pulse: frame aborted
// - ovf_glb_st   out  1      sticky global overflow
// - ovf_rtc_st   out  1      sticky RTC overflow
// BEHAVIOUR
// Timing and reset
// - All inputs except clr_status and rd_addr pass through SYNC_STAGES flops.
// - Cycle references below are on the synchronised signals.
// - Reset: FSM=IDLE; regfile, flags and valid bits=0; all outputs=0.
// - Reset mid-frame discards the partial word; no word_valid or frame_err is raised.
// FSM
// - IDLE: stay until sl=1, then go to LOAD.
// - LOAD: latch addr_in every cycle sl=1.
//   - First cycle with sl=0: sample serial_in as the MSB, set bitcnt=1, go to SHIFT.
// - SHIFT: sl=0 shifts one bit per cycle.
//   - On the cycle bitcnt reaches WIDTH (last bit sampled): latch ovf_ch_in, go to DONE.
//   - sl=1 before bit WIDTH: frame_err pulse next cycle, partial word discarded, go to LOAD (re-latch addr).
// - DONE (1 cycle): word_valid=1 with word_addr/word_data; regfile[addr] written; valid bit set.
//   - sl=1: go to LOAD. sl=0: go to WAIT.
// - WAIT: extra sl=0 cycles are ignored with no error; sl=1 goes to LOAD.
// - Latency: word_valid asserts 1 cycle after the last bit is sampled (SYNC_STAGES+1 after the pin).
// - WIDTH=1 is legal: LOAD goes straight to DONE.
// - Readout: a read of the address being written in DONE returns the old value that cycle and the new value the next.
// Status
// - ovf_glb_st / ovf_rtc_st set on any sampled 1 and held until clr_status.
// - clr_status and a set in the same cycle: set wins.
// STRUCTURE
// - cnt_ser_pkg: ADDR_W=3, NCH=8, state enum {IDLE,LOAD,SHIFT,DONE,WAIT}.
// - One sub-module: sync_ff, an N-stage synchroniser (pass-through at 0), one instance per input.
// - Local pieces: shift reg, bitcnt ($clog2(WIDTH+1)), regfile NCH x (WIDTH+1), valid vector.
// TESTING
// - Frame addr=5, word 0xA5C3, ovf_ch=0
//   -> one word_valid, word_addr=5, word_data=0xA5C3; rd_addr=5 gives 0xA5C3, rd_valid=1.
// - Back-to-back frames to addr 0..7 with word=addr*0x1111, no idle between them
//   -> 8 word_valid pulses; all 8 entries correct.
// - sl_in rises after 9 of 16 bits
//   -> frame_err pulse, no word_valid, regfile unchanged; the next full frame is received correctly.
// - ovf_ch_in=1 on last bit to addr 2; ovf_glb pulse; clr_status asserted in the same cycle as an ovf_rtc pulse
//   -> rd_ovf(2)=1; ovf_glb_st=1; ovf_rtc_st=1.
// - Reset asserted at bit 8 of a frame
//   -> all outputs 0, no pulses, FSM=IDLE; the following frame decodes correctly.
// - 20 extra sl=0 cycles after a frame
//   -> a single word_valid, no frame_err.

Source files
------------

// File: rtl/counter_serial_rx_pkg.sv
// Shared types and sizes for the counter serial link receiver.
package cnt_ser_pkg;

    localparam int ADDR_W = 3;
    localparam int NCH    = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        WAIT  = 3'd4
    } state_t;

endpackage

// File: rtl/counter_serial_rx_sync_ff.sv
// N-stage input synchroniser; STAGES=0 is a plain wire for inputs already on clk.
module sync_ff #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (STAGES == 0) begin : g_pass
            assign q = d;
        end else begin : g_sync
            logic [W-1:0] pipe [STAGES];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= d;
                    for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign q = pipe[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/counter_serial_rx.sv
// Receive end of the multichannel counter serial link: deserialises framed words
// into a per-channel register file and keeps sticky overflow status.
module counter_serial_rx
    import cnt_ser_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    input  logic              sl_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              ovf_ch_in,
    input  logic              ovf_glb_in,
    input  logic              ovf_rtc_in,
    input  logic              clr_status,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_ovf,
    output logic              rd_valid,
    output logic              word_valid,
    output logic [ADDR_W-1:0] word_addr,
    output logic [WIDTH-1:0]  word_data,
    output logic              frame_err,
    output logic              ovf_glb_st,
    output logic              ovf_rtc_st,
    output state_t            state_dbg
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic              s_ser, s_sl, s_ovf_ch, s_glb, s_rtc;
    logic [ADDR_W-1:0] s_addr;

    sync_ff #(.W(1),      .STAGES(SYNC_STAGES)) u_sync_ser (.clk(clk), .reset(reset), .d(serial_in),  .q(s_ser));
    sync_ff #(.W(1),      .STAGES(SYNC_STAGES)) u_sync_sl  (.clk(clk), .reset(reset), .d(sl_in),      .q(s_sl));
    sync_ff #(.W(ADDR_W), .STAGES(SYNC_STAGES)) u_sync_adr (.clk(clk), .reset(reset), .d(addr_in),    .q(s_addr));
    sync_ff #(.W(1),      .STAGES(SYNC_STAGES)) u_sync_och (.clk(clk), .reset(reset), .d(ovf_ch_in),  .q(s_ovf_ch));
    sync_ff #(.W(1),      .STAGES(SYNC_STAGES)) u_sync_glb (.clk(clk), .reset(reset), .d(ovf_glb_in), .q(s_glb));
    sync_ff #(.W(1),      .STAGES(SYNC_STAGES)) u_sync_rtc (.clk(clk), .reset(reset), .d(ovf_rtc_in), .q(s_rtc));

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bitcnt_q;
    logic [WIDTH-1:0]  shreg_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ovf_ch_q;
    logic              frame_err_q;
    logic              glb_st_q, rtc_st_q;
    logic [WIDTH:0]    regfile_q [NCH];
    logic [NCH-1:0]    valid_q;

    // Concatenate then drop the top bit so WIDTH=1 needs no special-case slice.
    logic [WIDTH:0]    shift_cat;
    logic [WIDTH-1:0]  shreg_nxt;
    assign shift_cat = {shreg_q, s_ser};
    assign shreg_nxt = shift_cat[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (s_sl) state_d = LOAD;
            LOAD:    if (!s_sl) state_d = (WIDTH == 1) ? DONE : SHIFT;
            SHIFT: begin
                if (s_sl)                       state_d = LOAD;
                else if (bitcnt_q == CNT_LAST)  state_d = DONE;
            end
            DONE:    state_d = s_sl ? LOAD : WAIT;
            WAIT:    if (s_sl) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        word_valid = (state_q == DONE);
        word_addr  = word_valid ? addr_q  : '0;
        word_data  = word_valid ? shreg_q : '0;
        frame_err  = frame_err_q;
        ovf_glb_st = glb_st_q;
        ovf_rtc_st = rtc_st_q;
        state_dbg  = state_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            addr_q      <= '0;
            ovf_ch_q    <= 1'b0;
            frame_err_q <= 1'b0;
            glb_st_q    <= 1'b0;
            rtc_st_q    <= 1'b0;
            valid_q     <= '0;
            for (int i = 0; i < NCH; i++) regfile_q[i] <= '0;
        end else begin
            if (s_sl) addr_q <= s_addr;
            frame_err_q <= (state_q == SHIFT) && s_sl;
            // Set beats a coincident clear.
            glb_st_q <= s_glb | (glb_st_q & ~clr_status);
            rtc_st_q <= s_rtc | (rtc_st_q & ~clr_status);
            case (state_q)
                LOAD: if (!s_sl) begin
                    shreg_q  <= shreg_nxt;
                    bitcnt_q <= CNT_W'(1);
                    ovf_ch_q <= s_ovf_ch;
                end
                SHIFT: if (!s_sl) begin
                    shreg_q  <= shreg_nxt;
                    bitcnt_q <= bitcnt_q + CNT_W'(1);
                    if (bitcnt_q == CNT_LAST) ovf_ch_q <= s_ovf_ch;
                end
                DONE: begin
                    regfile_q[addr_q] <= {ovf_ch_q, shreg_q};
                    valid_q[addr_q]   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rd_data  = regfile_q[rd_addr][WIDTH-1:0];
    assign rd_ovf   = regfile_q[rd_addr][WIDTH];
    assign rd_valid = valid_q[rd_addr];

endmodule

// File: tb/tb_counter_serial_rx.sv
// Directed bench for counter_serial_rx: vector table for back-to-back frames plus
// hand-written abort, overflow, reset and trailing-idle sequences.
module tb_counter_serial_rx;
    import cnt_ser_pkg::*;

    localparam int W  = 16;
    localparam int WW = ADDR_W + W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              serial_in = 1'b0, sl_in = 1'b0;
    logic [ADDR_W-1:0] addr_in = '0;
    logic              ovf_ch_in = 1'b0, ovf_glb_in = 1'b0, ovf_rtc_in = 1'b0, clr_status = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [W-1:0]      rd_data, word_data;
    logic              rd_ovf, rd_valid, word_valid, frame_err, ovf_glb_st, ovf_rtc_st;
    logic [ADDR_W-1:0] word_addr;
    state_t            state_dbg;

    counter_serial_rx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .serial_in(serial_in), .sl_in(sl_in), .addr_in(addr_in),
        .ovf_ch_in(ovf_ch_in), .ovf_glb_in(ovf_glb_in), .ovf_rtc_in(ovf_rtc_in),
        .clr_status(clr_status), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ovf(rd_ovf),
        .rd_valid(rd_valid), .word_valid(word_valid), .word_addr(word_addr),
        .word_data(word_data), .frame_err(frame_err), .ovf_glb_st(ovf_glb_st),
        .ovf_rtc_st(ovf_rtc_st), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Monitor: records every completed word and counts frame errors on the falling edge.
    logic [WW-1:0] got_word [256];
    int            got_cyc  [256];
    int            got_cnt = 0;
    int            err_cnt = 0;
    int            mon_cyc = 0;

    always @(negedge clk) begin
        mon_cyc = mon_cyc + 1;
        if (word_valid && got_cnt < 256) begin
            got_word[got_cnt] = {word_addr, word_data};
            got_cyc[got_cnt]  = mon_cyc;
            got_cnt = got_cnt + 1;
        end
        if (frame_err) err_cnt = err_cnt + 1;
    end

    logic [WW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int rd_ptr  = 0;
    int last_bit_cyc = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [W-1:0]      data;
        logic [W-1:0]      exp_data;
        logic              exp_ovf;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            sl_in = 1'b0; serial_in = 1'b0; ovf_ch_in = 1'b0;
        end
    endtask

    // One load cycle then nbits shift cycles, MSB first; ovf_ch rides on bit WIDTH.
    task automatic send_frame(input logic [ADDR_W-1:0] a, input logic [W-1:0] d,
                              input logic ovf, input int nbits);
        tick();
        sl_in = 1'b1; addr_in = a; serial_in = 1'b0; ovf_ch_in = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            tick();
            sl_in     = 1'b0;
            serial_in = d[W-1-i];
            ovf_ch_in = (i == W-1) ? ovf : 1'b0;
        end
        last_bit_cyc = mon_cyc;
        if (nbits == W) exp_q.push_back({a, d});
    endtask

    task automatic drain_check(input string name);
        logic [WW-1:0] e;
        while (rd_ptr < got_cnt) begin
            if (exp_q.size() == 0) begin
                check({name, "_unexpected_word"}, got_word[rd_ptr], 32'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check({name, "_word"}, got_word[rd_ptr], e);
            end
            rd_ptr++;
        end
        check({name, "_missing_words"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic read_check(input string name, input logic [ADDR_W-1:0] a,
                              input logic [W-1:0] d, input logic o, input logic v);
        rd_addr = a;
        #1;
        check({name, "_rd_data"},  rd_data,  d);
        check({name, "_rd_ovf"},   rd_ovf,   o);
        check({name, "_rd_valid"}, rd_valid, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, e0, idx;

        for (int i = 0; i < 8; i++) begin
            vecs[i].addr     = ADDR_W'(i);
            vecs[i].data     = W'(i * 16'h1111);
            vecs[i].exp_data = W'(i * 16'h1111);
            vecs[i].exp_ovf  = 1'b0;
        end

        // Reset state
        repeat (3) tick();
        check("rst_state",      state_dbg,  IDLE);
        check("rst_word_valid", word_valid, 0);
        check("rst_frame_err",  frame_err,  0);
        check("rst_status",     {ovf_glb_st, ovf_rtc_st}, 0);
        read_check("rst", 3'd5, 16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
        idle(2);

        // Single frame to addr 5
        w0 = got_cnt; idx = got_cnt;
        send_frame(3'd5, 16'hA5C3, 1'b0, W);
        idle(6);
        check("single_count", got_cnt - w0, 1);
        check("single_latency", got_cyc[idx] - last_bit_cyc, 4);
        drain_check("single");
        read_check("single", 3'd5, 16'hA5C3, 1'b0, 1'b1);
        read_check("single_other", 3'd4, 16'h0000, 1'b0, 1'b0);

        // Back-to-back frames from the vector table
        w0 = got_cnt;
        for (int i = 0; i < 8; i++) send_frame(vecs[i].addr, vecs[i].data, 1'b0, W);
        idle(6);
        check("b2b_count", got_cnt - w0, 8);
        drain_check("b2b");
        for (int i = 0; i < 8; i++)
            read_check($sformatf("b2b_entry%0d", i), vecs[i].addr, vecs[i].exp_data,
                       vecs[i].exp_ovf, 1'b1);

        // Abort after 9 bits, hold load phase, then a full frame
        w0 = got_cnt; e0 = err_cnt;
        send_frame(3'd6, 16'hFFFF, 1'b0, 9);
        repeat (5) begin
            tick();
            sl_in = 1'b1; addr_in = 3'd6; serial_in = 1'b0;
        end
        check("abort_err_count", err_cnt - e0, 1);
        check("abort_no_word", got_cnt - w0, 0);
        read_check("abort_unchanged", 3'd6, 16'h6666, 1'b0, 1'b1);
        send_frame(3'd6, 16'h1234, 1'b0, W);
        idle(6);
        check("abort_next_count", got_cnt - w0, 1);
        check("abort_err_final", err_cnt - e0, 1);
        drain_check("abort_next");
        read_check("abort_next", 3'd6, 16'h1234, 1'b0, 1'b1);

        // Channel overflow flag and sticky status
        send_frame(3'd2, 16'h0F00, 1'b1, W);
        idle(6);
        drain_check("ovf_frame");
        read_check("ovf_ch2", 3'd2, 16'h0F00, 1'b1, 1'b1);
        read_check("ovf_ch3", 3'd3, 16'h3333, 1'b0, 1'b1);
        tick(); ovf_glb_in = 1'b1;
        tick(); ovf_glb_in = 1'b0;
        idle(4);
        check("glb_set", {ovf_glb_st, ovf_rtc_st}, 2'b10);
        tick(); clr_status = 1'b1;
        tick(); clr_status = 1'b0;
        check("status_cleared", {ovf_glb_st, ovf_rtc_st}, 2'b00);
        tick(); ovf_rtc_in = 1'b1;
        tick(); ovf_rtc_in = 1'b0;
        tick(); clr_status = 1'b1;
        tick(); clr_status = 1'b0;
        idle(2);
        check("rtc_set_wins", {ovf_glb_st, ovf_rtc_st}, 2'b01);
        tick(); ovf_glb_in = 1'b1;
        tick(); ovf_glb_in = 1'b0;
        idle(4);
        check("both_set", {ovf_glb_st, ovf_rtc_st}, 2'b11);

        // Reset at bit 8 of a frame
        w0 = got_cnt; e0 = err_cnt;
        tick(); sl_in = 1'b1; addr_in = 3'd1;
        for (int i = 0; i < 8; i++) begin
            tick(); sl_in = 1'b0; serial_in = 1'b1;
        end
        tick(); reset = 1'b1; serial_in = 1'b0;
        tick();
        check("midrst_state",  state_dbg, IDLE);
        check("midrst_outs",   {word_valid, frame_err, ovf_glb_st, ovf_rtc_st, word_addr}, 0);
        check("midrst_wdata",  word_data, 0);
        read_check("midrst", 3'd1, 16'h0000, 1'b0, 1'b0);
        tick(); reset = 1'b0;
        idle(4);
        check("midrst_no_pulses", {got_cnt - w0, err_cnt - e0}, 0);
        send_frame(3'd1, 16'hBEEF, 1'b0, W);
        idle(6);
        check("midrst_next_count", got_cnt - w0, 1);
        drain_check("midrst_next");
        read_check("midrst_next", 3'd1, 16'hBEEF, 1'b0, 1'b1);

        // Long idle after a frame
        w0 = got_cnt; e0 = err_cnt;
        send_frame(3'd7, 16'h0F0F, 1'b0, W);
        idle(20);
        check("idle20_words", got_cnt - w0, 1);
        check("idle20_errs", err_cnt - e0, 0);
        check("idle20_state", state_dbg, WAIT);
        drain_check("idle20");
        read_check("idle20", 3'd7, 16'h0F0F, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
